// File: rtl/fp_cmult16_lane_seq.sv
// Serial-to-lane sequencer for the FP complex multiplier array: packs (sample, twiddle)
// pairs into lane operands, waits out the multiplier latency, then replays lane results serially.
module fp_cmult16_lane_seq #(
    parameter int unsigned LANES    = 16,
    parameter int unsigned W        = 32,
    parameter int unsigned MULT_LAT = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [W-1:0]              in_re,
    input  logic [W-1:0]              in_im,
    input  logic [W-1:0]              in_tw_re,
    input  logic [W-1:0]              in_tw_im,
    input  logic                      in_last,
    output logic [LANES-1:0][W-1:0]   mul_a,
    output logic [LANES-1:0][W-1:0]   mul_b,
    output logic [LANES-1:0][W-1:0]   mul_c,
    output logic [LANES-1:0][W-1:0]   mul_d,
    input  logic [LANES-1:0][W-1:0]   mul_q,
    input  logic [LANES-1:0][W-1:0]   mul_r,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [W-1:0]              out_re,
    output logic [W-1:0]              out_im,
    output logic                      out_last,
    output logic                      busy
);

    localparam int unsigned IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned NL_W  = $clog2(LANES + 1);
    localparam int unsigned CNT_W = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;

    localparam logic [1:0] S_FILL  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]             state, state_nxt;
    logic [IDX_W-1:0]       idx, idx_nxt;
    logic [CNT_W-1:0]       cnt, cnt_nxt;
    logic [NL_W-1:0]        nlanes, nlanes_nxt;
    logic [LANES-1:0][W-1:0] a_nxt, b_nxt, c_nxt, d_nxt;
    logic [LANES-1:0][W-1:0] qbuf, rbuf, qbuf_nxt, rbuf_nxt;
    logic                   in_ready_nxt, out_valid_nxt, out_last_nxt, busy_nxt;
    logic [W-1:0]           out_re_nxt, out_im_nxt;

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        cnt_nxt    = cnt;
        nlanes_nxt = nlanes;
        a_nxt      = mul_a;
        b_nxt      = mul_b;
        c_nxt      = mul_c;
        d_nxt      = mul_d;
        qbuf_nxt   = qbuf;
        rbuf_nxt   = rbuf;

        case (state)
            S_FILL: begin
                if (in_valid && in_ready) begin
                    a_nxt[idx] = in_re;
                    b_nxt[idx] = in_im;
                    c_nxt[idx] = in_tw_re;
                    d_nxt[idx] = in_tw_im;
                    if (in_last || (idx == IDX_W'(LANES - 1))) begin
                        // Short frame: clear the unused upper lanes on the closing edge
                        for (int unsigned l = 0; l < LANES; l++) begin
                            if (l > 32'(idx)) begin
                                a_nxt[l] = '0;
                                b_nxt[l] = '0;
                                c_nxt[l] = '0;
                                d_nxt[l] = '0;
                            end
                        end
                        nlanes_nxt = NL_W'(idx) + NL_W'(1);
                        state_nxt  = S_WAIT;
                        idx_nxt    = '0;
                        cnt_nxt    = '0;
                    end else begin
                        idx_nxt = idx + IDX_W'(1);
                    end
                end
            end
            S_WAIT: begin
                if (cnt == CNT_W'(MULT_LAT - 1)) begin
                    qbuf_nxt  = mul_q;
                    rbuf_nxt  = mul_r;
                    state_nxt = S_DRAIN;
                    idx_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_DRAIN: begin
                if (out_valid && out_ready) begin
                    if ((NL_W'(idx) + NL_W'(1)) == nlanes) begin
                        state_nxt = S_FILL;
                        idx_nxt   = '0;
                    end else begin
                        idx_nxt = idx + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_nxt = S_FILL;
                idx_nxt   = '0;
            end
        endcase

        in_ready_nxt  = (state_nxt == S_FILL);
        out_valid_nxt = (state_nxt == S_DRAIN);
        out_last_nxt  = out_valid_nxt && ((NL_W'(idx_nxt) + NL_W'(1)) == nlanes_nxt);
        busy_nxt      = !((state_nxt == S_FILL) && (idx_nxt == '0));
        out_re_nxt    = out_valid_nxt ? qbuf_nxt[idx_nxt] : '0;
        out_im_nxt    = out_valid_nxt ? rbuf_nxt[idx_nxt] : '0;
    end

    // State, operand/result storage and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_FILL;
            idx       <= '0;
            cnt       <= '0;
            nlanes    <= '0;
            mul_a     <= '0;
            mul_b     <= '0;
            mul_c     <= '0;
            mul_d     <= '0;
            qbuf      <= '0;
            rbuf      <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            cnt       <= cnt_nxt;
            nlanes    <= nlanes_nxt;
            mul_a     <= a_nxt;
            mul_b     <= b_nxt;
            mul_c     <= c_nxt;
            mul_d     <= d_nxt;
            qbuf      <= qbuf_nxt;
            rbuf      <= rbuf_nxt;
            in_ready  <= in_ready_nxt;
            out_valid <= out_valid_nxt;
            out_last  <= out_last_nxt;
            busy      <= busy_nxt;
            out_re    <= out_re_nxt;
            out_im    <= out_im_nxt;
        end
    end

endmodule

// File: tb/tb_fp_cmult16_lane_seq.sv
// Bench for fp_cmult16_lane_seq: latency-checked integer complex-multiply stub plus a
// queue-based frame model; random data, gaps and backpressure.
module tb_fp_cmult16_lane_seq;

    localparam int unsigned LANES    = 16;
    localparam int unsigned W        = 32;
    localparam int unsigned MULT_LAT = 8;
    localparam logic [W-1:0] POISON  = 32'hDEAD_BEEF;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    in_valid, in_ready, in_last;
    logic [W-1:0]            in_re, in_im, in_tw_re, in_tw_im;
    logic [LANES-1:0][W-1:0] mul_a, mul_b, mul_c, mul_d, mul_q, mul_r;
    logic                    out_valid, out_ready, out_last, busy;
    logic [W-1:0]            out_re, out_im;

    fp_cmult16_lane_seq #(.LANES(LANES), .W(W), .MULT_LAT(MULT_LAT)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_re(in_re), .in_im(in_im), .in_tw_re(in_tw_re), .in_tw_im(in_tw_im), .in_last(in_last),
        .mul_a(mul_a), .mul_b(mul_b), .mul_c(mul_c), .mul_d(mul_d),
        .mul_q(mul_q), .mul_r(mul_r),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_re(out_re), .out_im(out_im), .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    // Multiplier stub: results are poison until operands have been stable for MULT_LAT cycles
    logic [4*LANES*W-1:0] ops, ops_prev = '0;
    int                   age = 0;
    assign ops = {mul_a, mul_b, mul_c, mul_d};

    always @(posedge clk) begin
        ops_prev <= ops;
        age      <= (ops != ops_prev) ? 1 : ((age < 255) ? age + 1 : age);
    end

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            if ((ops == ops_prev) && (age >= MULT_LAT - 1)) begin
                mul_q[l] = mul_a[l] * mul_c[l] - mul_b[l] * mul_d[l];
                mul_r[l] = mul_a[l] * mul_d[l] + mul_b[l] * mul_c[l];
            end else begin
                mul_q[l] = POISON;
                mul_r[l] = POISON;
            end
        end
    end

    int          checks   = 0;
    int          failures = 0;
    logic [W-1:0] fa[LANES], fb[LANES], fc[LANES], fd[LANES];
    logic [63:0] expq[$];
    int          cur_n = 0;
    longint      t_acc = 0;
    int          lat   = -1;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic rand_data();
        for (int k = 0; k < LANES; k++) begin
            fa[k] = $urandom; fb[k] = $urandom; fc[k] = $urandom; fd[k] = $urandom;
        end
    endtask

    // Present n pairs; the model records each accepted pair's complex product
    task automatic fill_frame(input int n, input bit gaps);
        int k = 0;
        int guard = 0;
        logic [W-1:0] q, r;
        cur_n = n;
        while (k < n) begin
            @(negedge clk);
            guard++;
            if (guard > 500) begin
                check("fill_timeout", 0, 1);
                in_valid = 1'b0;
                return;
            end
            check("fill_ready", in_ready, 1);
            if (k > 0) check("fill_busy", busy, 1);
            if (gaps && ($urandom_range(0, 2) == 0)) begin
                in_valid = 1'b0;
                in_re = $urandom; in_im = $urandom; in_tw_re = $urandom; in_tw_im = $urandom;
                in_last = 1'b1;
            end else begin
                in_valid = 1'b1;
                in_re = fa[k]; in_im = fb[k]; in_tw_re = fc[k]; in_tw_im = fd[k];
                in_last = (k == n - 1);
                q = fa[k] * fc[k] - fb[k] * fd[k];
                r = fa[k] * fd[k] + fb[k] * fc[k];
                expq.push_back({q, r});
                if (k == n - 1) t_acc = $time + 5;
                k++;
            end
        end
    endtask

    // Collect the frame; mode 0 always ready, 1 pattern 1,0,0,1, 2 random
    task automatic drain(input int mode, input bit hold);
        int  guard = 0;
        int  vcyc  = 0;
        bit  first = 1'b1;
        logic [127:0] exp_ops;
        while (expq.size() > 0) begin
            @(negedge clk);
            guard++;
            if (guard > 400) begin
                check("drain_timeout", 0, 1);
                expq.delete();
                break;
            end
            if (guard == 1) begin
                for (int j = 0; j < LANES; j++) begin
                    exp_ops = (j < cur_n) ? {fa[j], fb[j], fc[j], fd[j]} : '0;
                    check("mul_ops", {mul_a[j], mul_b[j], mul_c[j], mul_d[j]}, exp_ops);
                end
            end
            check("drain_ready", in_ready, 0);
            check("drain_busy", busy, 1);
            in_valid = hold;
            in_re = $urandom; in_im = $urandom; in_tw_re = $urandom; in_tw_im = $urandom;
            in_last = 1'($urandom_range(0, 1));
            if (out_valid) begin
                if (first) begin
                    first = 1'b0;
                    lat = int'(($time - t_acc - 5) / 10);
                end
                check("out_data", {out_re, out_im}, expq[0]);
                check("out_last", out_last, (expq.size() == 1));
                case (mode)
                    0:       out_ready = 1'b1;
                    1:       out_ready = ((vcyc % 4) == 0) || ((vcyc % 4) == 3);
                    default: out_ready = 1'($urandom_range(0, 1));
                endcase
                vcyc++;
                if (out_ready) void'(expq.pop_front());
            end else begin
                out_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            end
        end
        @(posedge clk);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("post_valid", out_valid, 0);
        check("post_ready", in_ready, 1);
        check("post_busy", busy, 0);
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        in_re = '0; in_im = '0; in_tw_re = '0; in_tw_im = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_mul", |{mul_a, mul_b, mul_c, mul_d}, 0);
        reset = 1'b1;

        // Full frame of (k+1)+0i x 1+0i
        for (int k = 0; k < LANES; k++) begin
            fa[k] = 32'(k + 1); fb[k] = '0; fc[k] = 32'd1; fd[k] = '0;
        end
        fill_frame(LANES, 1'b0);
        drain(0, 1'b0);
        check("latency", 32'(lat), 32'(MULT_LAT));

        // Short frame of 5 over a previously full operand set
        rand_data();
        fill_frame(5, 1'b0);
        drain(0, 1'b0);

        // Backpressure pattern
        rand_data();
        fill_frame(LANES, 1'b0);
        drain(1, 1'b0);

        // Input gaps, in_valid held through WAIT/DRAIN
        rand_data();
        fill_frame(LANES, 1'b1);
        drain(2, 1'b1);

        // Reset during WAIT
        rand_data();
        fill_frame(LANES, 1'b0);
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b0;
        #1;
        check("rst_wait_out_valid", out_valid, 0);
        check("rst_wait_in_ready", in_ready, 1);
        check("rst_wait_mul", |{mul_a, mul_b, mul_c, mul_d}, 0);
        expq.delete();
        @(negedge clk);
        reset = 1'b1;
        rand_data();
        fill_frame(LANES, 1'b0);
        drain(0, 1'b0);

        // (1+2i)(3+4i) = -5+10i on a single-lane frame
        fa[0] = 32'd1; fb[0] = 32'd2; fc[0] = 32'd3; fd[0] = 32'd4;
        fill_frame(1, 1'b0);
        drain(0, 1'b0);

        // Random frames
        for (int f = 0; f < 8; f++) begin
            rand_data();
            fill_frame($urandom_range(1, LANES), 1'($urandom_range(0, 1)));
            drain(2, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
